// File: rtl/deco_rob_issue_queue.sv
// Two-wide in-order issue queue between the decoder and backend ROB allocation.
// Accepts and releases up to two micro-ops per cycle; a flush empties it.
module deco_rob_issue_queue #(
    parameter int DATA_WIDTH = 160,
    parameter int DEPTH      = 8,
    localparam int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  enq_valid_first_i,
    input  logic                  enq_valid_second_i,
    input  logic [DATA_WIDTH-1:0] enq_data_first_i,
    input  logic [DATA_WIDTH-1:0] enq_data_second_i,
    output logic                  enq_ready_first_o,
    output logic                  enq_ready_second_o,
    output logic                  deq_valid_first_o,
    output logic                  deq_valid_second_o,
    output logic [DATA_WIDTH-1:0] deq_data_first_o,
    output logic [DATA_WIDTH-1:0] deq_data_second_o,
    input  logic                  deq_ready_first_i,
    input  logic                  deq_ready_second_i,
    output logic [PTR_WIDTH:0]    count_o
);
    localparam int CNT_W = PTR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_M2_C = CNT_W'(DEPTH - 2);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_WIDTH-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  enq0, enq1, deq0, deq1;

    // Handshakes look only at registered occupancy, so a full queue being
    // drained this cycle still refuses new entries until the next one.
    assign enq_ready_first_o  = (count_q < DEPTH_C);
    assign enq_ready_second_o = (count_q <= DEPTH_M2_C);
    assign deq_valid_first_o  = (count_q != '0);
    assign deq_valid_second_o = (count_q > CNT_W'(1));
    assign deq_data_first_o   = mem_q[head_q];
    assign deq_data_second_o  = mem_q[head_q + PTR_WIDTH'(1)];
    assign count_o            = count_q;

    always_comb begin
        enq0    = enq_valid_first_i & enq_ready_first_o;
        enq1    = enq_valid_second_i & enq_ready_second_o & enq0;
        deq0    = deq_valid_first_o & deq_ready_first_i;
        deq1    = deq_valid_second_o & deq_ready_second_i & deq0;
        head_d  = head_q + PTR_WIDTH'(deq0) + PTR_WIDTH'(deq1);
        tail_d  = tail_q + PTR_WIDTH'(enq0) + PTR_WIDTH'(enq1);
        count_d = count_q + CNT_W'(enq0) + CNT_W'(enq1) - CNT_W'(deq0) - CNT_W'(deq1);
        mem_d   = mem_q;
        if (!flush_i) begin
            if (enq0) mem_d[tail_q] = enq_data_first_i;
            if (enq1) mem_d[tail_q + PTR_WIDTH'(1)] = enq_data_second_i;
        end else begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage is never reset; validity comes from count_q alone.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    a_count_range: assert property (@(posedge clk) disable iff (!rst) count_q <= DEPTH_C);
endmodule

// File: doc/deco_rob_issue_queue.md
Name: deco_rob_issue_queue

Overview:
- Dual-ported in-order FIFO between the decoder and the backend dispatch/ROB allocation.
- Absorbs up to two decoded micro-ops per cycle and presents the oldest two as first/second slots to the backend request/ready handshake.
- Decouples decode throughput from backend stalls.
- Discards all contents on a global flush (trap/ret).

Parameters:
- DATA_WIDTH, 160, width of one packed decoded-instruction payload (pc, next_pc, predict_pc, regs, imm, fu controls).
- DEPTH, 8, number of entries; power of two, minimum 4.
- PTR_WIDTH, log2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-low
- flush_i  in  1  global_trap_i OR global_ret_i from the trap unit; clears queue
- enq_valid_first_i  in  1  decoder slot 0 valid
- enq_valid_second_i  in  1  decoder slot 1 valid; younger than slot 0
- enq_data_first_i  in  DATA_WIDTH  slot 0 payload
- enq_data_second_i  in  DATA_WIDTH  slot 1 payload
- enq_ready_first_o  out  1  at least 1 free entry
- enq_ready_second_o  out  1  at least 2 free entries
- deq_valid_first_o  out  1  oldest entry present (drives deco_rob_req_valid_first)
- deq_valid_second_o  out  1  second-oldest entry present
- deq_data_first_o  out  DATA_WIDTH  oldest entry payload
- deq_data_second_o  out  DATA_WIDTH  second-oldest entry payload
- deq_ready_first_i  in  1  backend accepts slot 0
- deq_ready_second_i  in  1  backend accepts slot 1
- count_o  out  PTR_WIDTH+1  current occupancy

Behaviour:
- State: storage array, head pointer, tail pointer (PTR_WIDTH, wrap modulo DEPTH), count register (0..DEPTH).
- Reset (rst=0 at clk edge): head=tail=0, count=0. Outputs then: all deq_valid 0, enq_ready_first/second 1, count_o 0. Storage is not cleared; deq_data is don't-care while invalid.
- Ready/valid are combinational from the registered count only; no same-cycle bypass.
  - enq_ready_first_o = (DEPTH-count >= 1); enq_ready_second_o = (DEPTH-count >= 2).
  - deq_valid_first_o = (count >= 1); deq_valid_second_o = (count >= 2).
  - deq_data_first_o = mem[head]; deq_data_second_o = mem[head+1 mod DEPTH].
- Enqueue:
  - enq0 = enq_valid_first_i & enq_ready_first_o.
  - enq1 = enq_valid_second_i & enq_ready_second_o & enq0.
  - Slot 1 is never written without slot 0 (order preserved); slot 1 valid alone is dropped and not acknowledged.
  - Writes go to mem[tail], then mem[tail+1]; tail advances by enq0+enq1.
  - Decoder must hold a non-accepted slot.
- Dequeue:
  - deq0 = deq_valid_first_o & deq_ready_first_i.
  - deq1 = deq_valid_second_o & deq_ready_second_i & deq0.
  - head advances by deq0+deq1.
- count_next = count + enq0 + enq1 - deq0 - deq1. Enqueue and dequeue in the same cycle are legal at any occupancy; ready is based on pre-dequeue count, so full + dequeue does not accept in that cycle.
- Latency: an entry enqueued at edge N is visible on deq at cycle N+1, minimum 1 cycle.
- Flush has priority over enqueue/dequeue. On a flush_i=1 edge: head=tail=0, count=0, same-cycle enq/deq ignored. Outputs are empty the next cycle.
- Reset overrides flush.
- Pointer wrap: entries spanning DEPTH-1→0 are read and written correctly for both slots.
- Invariant (assertion): count never exceeds DEPTH or goes below 0.

Test Plan:
- Reset/flow: hold rst=0 two cycles, release; enqueue pairs A,B then C,D with deq_ready both 1 from cycle 2 → deq presents A/B at cycle 1 after enqueue, then C/D; count_o returns to 0.
- Fill/backpressure: deq_ready=0, enqueue pairs until count=8 → enq_ready_second_o=0 at count 7, enq_ready_first_o=0 at count 8; extra valids not accepted, count stays 8.
- Odd occupancy: count=7, both enq valid → only first accepted, count=8; slot 1 held and accepted after one deq.
- Partial dequeue: count=3, deq_ready_first=0, deq_ready_second=1 → nothing consumed, count stays 3. deq_ready_first=1, second=0 → one consumed, new head = old second.
- Wrap: pre-advance head/tail to 7, enqueue X,Y (stored at 7 and 0) → deq_data_first=X, deq_data_second=Y.
- Flush: count=5 with simultaneous enqueue of 2 and flush_i=1 → next cycle count_o=0, deq_valid both 0, enq_ready both 1; the next enqueue appears at head.
